// File: rtl/pattern_mem_param.sv
// ---------------------------------------------------------------------------
// pattern_mem_param
//   Simple dual-port LED pattern store: one write port, one registered read
//   port. A hardware clear engine fills every entry with CLR_VAL after reset
//   release and whenever clr_start is seen while idle. The game-state logic
//   writes patterns, and the LED scan driver reads them.
//
// Parameters
//   DATA_W   word width in bits
//   DEPTH    number of entries (>=2, any value)
//   ADDR_W   derived address width, do not override
//   CLR_VAL  word written by the clear engine and returned for reads
//            at addresses beyond DEPTH-1
//   BYPASS   1: a same-edge write to the read address forwards data_in
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   write_enable/addr_wr/data_in   write port
//   rd_en/addr_rd            read request
//   data_out, rd_valid       registered read data and its 1-cycle strobe
//   clr_start                clear request (sampled only while idle)
//   busy                     clear engine running, port requests refused
//   clr_done                 pulse on the edge the last entry is cleared
//   wr_drop                  pulse after a refused write
// ---------------------------------------------------------------------------
module pattern_mem_param #(
  parameter int unsigned       DATA_W  = 10,
  parameter int unsigned       DEPTH   = 4,
  parameter int unsigned       ADDR_W  = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLR_VAL = '0,
  parameter bit                BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_drop_q, wr_drop_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy_w, wr_acc, rd_acc, wr_addr_ok, rd_addr_ok;

  assign busy_w     = (state_q == ST_CLEAR);
  assign wr_addr_ok = ({1'b0, addr_wr} < DEPTH_C);
  assign rd_addr_ok = ({1'b0, addr_rd} < DEPTH_C);
  assign wr_acc     = write_enable && !busy_w && wr_addr_ok;
  assign rd_acc     = rd_en && !busy_w;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    wr_drop_d  = write_enable && !wr_acc;
    rd_valid_d = rd_acc;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_wr;
    mem_wdata  = data_in;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLR_VAL;
        if (clr_cnt_q == LAST_C) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
          clr_cnt_d  = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ONE_C;
        end
      end
      ST_IDLE: begin
        // Port traffic on the clr_start edge is still served as idle traffic.
        mem_we = wr_acc;
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (rd_acc) begin
      if (!rd_addr_ok) begin
        data_out_d = CLR_VAL;
      end else if (BYPASS && wr_acc && (addr_wr == addr_rd)) begin
        data_out_d = data_in;
      end else begin
        data_out_d = mem[addr_rd];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the clear engine initialises it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy     = busy_w;
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;
  assign rd_valid = rd_valid_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_pattern_mem_param.sv
// ---------------------------------------------------------------------------
// tb_pattern_mem_param
//   Drives a BYPASS=1 and a BYPASS=0 instance (DEPTH=4) with identical
//   stimulus, compared cycle by cycle against a behavioural model through an
//   expectation queue, plus a DEPTH=5 instance with a non-zero CLR_VAL for
//   out-of-range addressing.
// ---------------------------------------------------------------------------
module tb_pattern_mem_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two DEPTH=4 instances.
  logic       we = 1'b0, rd_en = 1'b0, clr_start = 1'b0;
  logic [1:0] addr_wr = '0, addr_rd = '0;
  logic [9:0] data_in = '0;

  logic [9:0] data_out_a, data_out_b;
  logic       rd_valid_a, rd_valid_b, busy_a, busy_b;
  logic       clr_done_a, clr_done_b, wr_drop_a, wr_drop_b;

  // DEPTH=5 instance.
  logic       we_c = 1'b0, rd_en_c = 1'b0, clr_start_c = 1'b0;
  logic [2:0] addr_wr_c = '0, addr_rd_c = '0;
  logic [9:0] data_in_c = '0;
  logic [9:0] data_out_c;
  logic       rd_valid_c, busy_c, clr_done_c, wr_drop_c;

  pattern_mem_param #(.DATA_W(10), .DEPTH(4), .CLR_VAL(10'h000), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .addr_wr(addr_wr), .data_in(data_in),
    .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out_a), .rd_valid(rd_valid_a),
    .clr_start(clr_start), .busy(busy_a), .clr_done(clr_done_a), .wr_drop(wr_drop_a));

  pattern_mem_param #(.DATA_W(10), .DEPTH(4), .CLR_VAL(10'h000), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .addr_wr(addr_wr), .data_in(data_in),
    .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out_b), .rd_valid(rd_valid_b),
    .clr_start(clr_start), .busy(busy_b), .clr_done(clr_done_b), .wr_drop(wr_drop_b));

  pattern_mem_param #(.DATA_W(10), .DEPTH(5), .CLR_VAL(10'h155), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .write_enable(we_c), .addr_wr(addr_wr_c), .data_in(data_in_c),
    .rd_en(rd_en_c), .addr_rd(addr_rd_c), .data_out(data_out_c), .rd_valid(rd_valid_c),
    .clr_start(clr_start_c), .busy(busy_c), .clr_done(clr_done_c), .wr_drop(wr_drop_c));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       vld;
    logic [9:0] da;
    logic [9:0] db;
    logic       busy;
    logic       done;
    logic       drop;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model of the DEPTH=4 instances.
  logic [9:0] m_mem [4];
  logic       m_busy;
  int         m_cnt;
  logic [9:0] m_dout_a, m_dout_b;

  task automatic model_reset();
    m_busy   = 1'b1;
    m_cnt    = 0;
    m_dout_a = '0;
    m_dout_b = '0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    we = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    addr_wr = '0; addr_rd = '0; data_in = '0;
  endtask

  // Predicts the coming edge, pushes the prediction, advances one clock and
  // pops/compares it against both DEPTH=4 instances.
  task automatic drive_cycle();
    exp_t e;
    logic wr_ok, rd_ok;
    wr_ok  = we && !m_busy;
    rd_ok  = rd_en && !m_busy;
    e.vld  = rd_ok;
    e.drop = we && !wr_ok;
    e.done = 1'b0;
    if (rd_ok) begin
      m_dout_a = (wr_ok && addr_wr == addr_rd) ? data_in : m_mem[addr_rd];
      m_dout_b = m_mem[addr_rd];
    end
    e.da = m_dout_a;
    e.db = m_dout_b;
    if (m_busy) begin
      m_mem[m_cnt] = 10'h000;
      if (m_cnt == 3) begin
        m_busy = 1'b0;
        m_cnt  = 0;
        e.done = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (wr_ok) m_mem[addr_wr] = data_in;
      if (clr_start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    e.busy = m_busy;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({rd_valid_a, rd_valid_b} !== {e.vld, e.vld}) begin
      n_errors++;
      $display("FAIL sb_rd_valid t=%0t got a=%b b=%b expected %b", $time, rd_valid_a, rd_valid_b, e.vld);
    end
    n_checks++;
    if (data_out_a !== e.da) begin
      n_errors++;
      $display("FAIL sb_data_out_a t=%0t got %h expected %h", $time, data_out_a, e.da);
    end
    n_checks++;
    if (data_out_b !== e.db) begin
      n_errors++;
      $display("FAIL sb_data_out_b t=%0t got %h expected %h", $time, data_out_b, e.db);
    end
    n_checks++;
    if ({busy_a, clr_done_a, wr_drop_a, busy_b, clr_done_b, wr_drop_b} !==
        {e.busy, e.done, e.drop, e.busy, e.done, e.drop}) begin
      n_errors++;
      $display("FAIL sb_status t=%0t got busy/done/drop a=%b%b%b b=%b%b%b expected %b%b%b",
               $time, busy_a, clr_done_a, wr_drop_a, busy_b, clr_done_b, wr_drop_b,
               e.busy, e.done, e.drop);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs idle cycles until clr_done, bounded; returns edges taken (-1 on timeout).
  task automatic wait_clear(output int edges);
    edges = -1;
    idle_inputs();
    for (int i = 1; i <= 20; i++) begin
      drive_cycle();
      if (clr_done_a) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      rd_en = 1'b1; addr_rd = 2'(i);
      drive_cycle();
    end
    idle_inputs();
    drive_cycle();
  endtask

  task automatic test_reset();
    int edges;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b111 || data_out_a !== 10'h000 ||
        {rd_valid_a, clr_done_a, wr_drop_a} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_state got busy=%b%b%b dout=%h rv/done/drop=%b%b%b expected 111 000 000",
               busy_a, busy_b, busy_c, data_out_a, rd_valid_a, clr_done_a, wr_drop_a);
    end
    release_reset();
    wait_clear(edges);
    n_checks++;
    if (edges != 4) begin
      n_errors++;
      $display("FAIL reset_clear_len got %0d edges expected 4", edges);
    end
    read_all();
  endtask

  task automatic test_write_read();
    logic [9:0] vals [4];
    vals[0] = 10'h002; vals[1] = 10'h008; vals[2] = 10'h020; vals[3] = 10'h100;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      we = 1'b1; addr_wr = 2'(i); data_in = vals[i];
      drive_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      rd_en = 1'b1; addr_rd = 2'(i);
      drive_cycle();
      n_checks++;
      if (data_out_a !== vals[i] || rd_valid_a !== 1'b1) begin
        n_errors++;
        $display("FAIL write_read addr%0d got %h/%b expected %h/1", i, data_out_a, rd_valid_a, vals[i]);
      end
    end
    idle_inputs();
    drive_cycle();
  endtask

  task automatic test_collision();
    idle_inputs();
    we = 1'b1; addr_wr = 2'd2; data_in = 10'h3FF;
    rd_en = 1'b1; addr_rd = 2'd2;
    drive_cycle();
    n_checks++;
    if (data_out_a !== 10'h3FF || data_out_b !== 10'h020) begin
      n_errors++;
      $display("FAIL collision got bypass=%h nobypass=%h expected 3ff 020", data_out_a, data_out_b);
    end
    idle_inputs();
    rd_en = 1'b1; addr_rd = 2'd2;
    drive_cycle();
    n_checks++;
    if (data_out_a !== 10'h3FF || data_out_b !== 10'h3FF) begin
      n_errors++;
      $display("FAIL collision_after got %h %h expected 3ff 3ff", data_out_a, data_out_b);
    end
  endtask

  task automatic test_clear_busy();
    int edges;
    idle_inputs();
    clr_start = 1'b1;
    drive_cycle();
    // Still requesting clear while busy, plus port traffic that must be refused.
    clr_start = 1'b1;
    we = 1'b1; addr_wr = 2'd3; data_in = 10'h2AA;
    rd_en = 1'b1; addr_rd = 2'd1;
    drive_cycle();
    n_checks++;
    if (wr_drop_a !== 1'b1 || rd_valid_a !== 1'b0 || data_out_a !== 10'h3FF) begin
      n_errors++;
      $display("FAIL busy_ports got drop=%b rv=%b dout=%h expected 1 0 3ff", wr_drop_a, rd_valid_a, data_out_a);
    end
    wait_clear(edges);
    n_checks++;
    if (edges != 3) begin
      n_errors++;
      $display("FAIL clear_len got %0d more edges expected 3 (4 total)", edges);
    end
    idle_inputs();
    rd_en = 1'b1; addr_rd = 2'd3;
    drive_cycle();
    n_checks++;
    if (data_out_a !== 10'h000 || rd_valid_a !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_target got %h/%b expected 000/1", data_out_a, rd_valid_a);
    end
    read_all();
  endtask

  task automatic test_reset_mid_clear();
    int edges;
    idle_inputs();
    we = 1'b1; addr_wr = 2'd0; data_in = 10'h155;
    drive_cycle();
    idle_inputs();
    rd_en = 1'b1; addr_rd = 2'd0;
    drive_cycle();
    idle_inputs();
    clr_start = 1'b1;
    drive_cycle();
    idle_inputs();
    drive_cycle();
    drive_cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (data_out_a !== 10'h000 || busy_a !== 1'b1 || {rd_valid_a, clr_done_a, wr_drop_a} !== 3'b000) begin
      n_errors++;
      $display("FAIL mid_clear_reset got dout=%h busy=%b rv/done/drop=%b%b%b expected 000 1 000",
               data_out_a, busy_a, rd_valid_a, clr_done_a, wr_drop_a);
    end
    release_reset();
    wait_clear(edges);
    n_checks++;
    if (edges != 4) begin
      n_errors++;
      $display("FAIL mid_clear_len got %0d edges expected 4", edges);
    end
  endtask

  task automatic test_depth5();
    int waited = 0;
    while (busy_c === 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (busy_c !== 1'b0) begin
      n_errors++;
      $display("FAIL d5_idle got busy=%b expected 0", busy_c);
    end
    we_c = 1'b1; addr_wr_c = 3'd4; data_in_c = 10'h0AB;
    @(posedge clk); #1;
    n_checks++;
    if (wr_drop_c !== 1'b0) begin
      n_errors++;
      $display("FAIL d5_wr4_drop got %b expected 0", wr_drop_c);
    end
    addr_wr_c = 3'd6; data_in_c = 10'h3C3;
    @(posedge clk); #1;
    n_checks++;
    if (wr_drop_c !== 1'b1) begin
      n_errors++;
      $display("FAIL d5_wr6_drop got %b expected 1", wr_drop_c);
    end
    we_c = 1'b0;
    rd_en_c = 1'b1; addr_rd_c = 3'd6;
    @(posedge clk); #1;
    n_checks++;
    if (data_out_c !== 10'h155 || rd_valid_c !== 1'b1 || wr_drop_c !== 1'b0) begin
      n_errors++;
      $display("FAIL d5_rd6 got %h/%b drop=%b expected 155/1 drop=0", data_out_c, rd_valid_c, wr_drop_c);
    end
    addr_rd_c = 3'd4;
    @(posedge clk); #1;
    n_checks++;
    if (data_out_c !== 10'h0AB || rd_valid_c !== 1'b1) begin
      n_errors++;
      $display("FAIL d5_rd4 got %h/%b expected 0ab/1", data_out_c, rd_valid_c);
    end
    addr_rd_c = 3'd3;
    @(posedge clk); #1;
    n_checks++;
    if (data_out_c !== 10'h155) begin
      n_errors++;
      $display("FAIL d5_rd3 got %h expected 155", data_out_c);
    end
    rd_en_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_clear_busy();
    test_reset_mid_clear();
    test_depth5();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete by t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
